// File: rtl/dcim_pkg.sv
// Shared types and constants for the TinyDCIM sequencer.
// DCIM_SIGNED_ACT_EN selects two's-complement activations.
package dcim_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_LOAD_A,
      S_COMPUTE,
      S_DRAIN
   } state_e;

   localparam logic [7:0] OP_LOAD_W = 8'h01;
   localparam logic [7:0] OP_RUN    = 8'h02;

   localparam int ACC_W     = 24;
   localparam int RES_BYTES = 3;
   localparam int ACT_BITS  = 8;

endpackage

// File: rtl/dcim_if.sv
// Host byte bus of the sequencer: command in, result out.
interface dcim_if;

   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_data;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;

   modport master (
      output cmd_valid, cmd_data, res_ready,
      input  cmd_ready, res_valid, res_data
   );

   modport slave (
      input  cmd_valid, cmd_data, res_ready,
      output cmd_ready, res_valid, res_data
   );

endinterface

// File: rtl/dcim_byte_ser.sv
// Loads a 24-bit word and streams it out LSB byte first
// over a valid/ready port; done_o marks the last handshake.
module dcim_byte_ser
   import dcim_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [ACC_W-1:0] data_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [7:0]       data_o,
   output logic             done_o
);

   logic [ACC_W-1:0] sh_q, sh_d;
   logic             valid_q, valid_d;
   logic [1:0]       idx_q, idx_d;
   logic             hs;

   assign hs      = valid_q && ready_i;
   assign done_o  = hs && (idx_q == 2'(RES_BYTES - 1));
   assign valid_o = valid_q;
   assign data_o  = sh_q[7:0];

   always_comb begin
      sh_d    = sh_q;
      valid_d = valid_q;
      idx_d   = idx_q;
      if (load_i) begin
         sh_d    = data_i;
         valid_d = 1'b1;
         idx_d   = '0;
      end else if (hs) begin
         sh_d  = sh_q >> 8;
         idx_d = idx_q + 2'd1;
         if (done_o) valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_q    <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         sh_q    <= sh_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: rtl/dcim_seq_ctrl.sv
// TinyDCIM sequencer: byte-stream decode, bit-serial compute, result drain.
// Define DCIM_SIGNED_ACT_EN for two's-complement activations.
module dcim_seq_ctrl
   import dcim_pkg::*;
#(
   parameter int ROWS = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   dcim_if.slave                     bus,
   output logic                      busy,
   output logic                      err,
   output logic                      arr_wr_en,
   output logic [$clog2(ROWS)-1:0]   arr_row,
   output logic [7:0]                arr_wdata,
   output logic [ROWS-1:0]           arr_act,
   input  logic [8+$clog2(ROWS)-1:0] arr_psum
);

   localparam int RW = $clog2(ROWS);

   state_e           state_q, state_d;
   logic [RW-1:0]    cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             err_q, err_d;
   logic             wr_en_q, wr_en_d;
   logic [RW-1:0]    row_q, row_d;
   logic [7:0]       wdata_q, wdata_d;
   logic [7:0]       act_q [ROWS];
   logic             act_we;
   logic             xfer;
   logic             last;
   logic             ser_load;
   logic             ser_done;
   logic [ACC_W-1:0] psum_ext;

   assign bus.cmd_ready = (state_q == S_IDLE)
                       || (state_q == S_LOAD_W)
                       || (state_q == S_LOAD_A);
   assign xfer      = bus.cmd_valid && bus.cmd_ready;
   assign last      = (cnt_q == RW'(ROWS - 1));
   assign psum_ext  = ACC_W'(arr_psum);
   assign busy      = (state_q != S_IDLE);
   assign err       = err_q;
   assign arr_wr_en = wr_en_q;
   assign arr_row   = row_q;
   assign arr_wdata = wdata_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      acc_d    = acc_q;
      err_d    = err_q;
      wr_en_d  = 1'b0;
      row_d    = row_q;
      wdata_d  = wdata_q;
      act_we   = 1'b0;
      ser_load = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (xfer) begin
               cnt_d = '0;
               unique case (1'b1)
                  (bus.cmd_data == OP_LOAD_W): begin
                     state_d = S_LOAD_W;
                     err_d   = 1'b0;
                  end
                  (bus.cmd_data == OP_RUN): begin
                     state_d = S_LOAD_A;
                     err_d   = 1'b0;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         S_LOAD_W: begin
            if (xfer) begin
               wr_en_d = 1'b1;
               row_d   = cnt_q;
               wdata_d = bus.cmd_data;
               cnt_d   = cnt_q + 1'b1;
               if (last) state_d = S_IDLE;
            end
         end
         S_LOAD_A: begin
            if (xfer) begin
               act_we = 1'b1;
               cnt_d  = cnt_q + 1'b1;
               if (last) begin
                  state_d = S_COMPUTE;
                  acc_d   = '0;
                  bit_d   = 3'(ACT_BITS - 1);
               end
            end
         end
         S_COMPUTE: begin
`ifdef DCIM_SIGNED_ACT_EN
            // MSB plane carries negative weight
            if (bit_q == 3'(ACT_BITS - 1))
               acc_d = (acc_q << 1) - psum_ext;
            else
               acc_d = (acc_q << 1) + psum_ext;
`else
            acc_d = (acc_q << 1) + psum_ext;
`endif
            bit_d = bit_q - 3'd1;
            if (bit_q == 3'd0) begin
               state_d  = S_DRAIN;
               ser_load = 1'b1;
            end
         end
         S_DRAIN: begin
            if (ser_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      arr_act = '0;
      if (state_q == S_COMPUTE)
         for (int r = 0; r < ROWS; r++)
            arr_act[r] = act_q[r][bit_q];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         acc_q   <= '0;
         err_q   <= 1'b0;
         wr_en_q <= 1'b0;
         row_q   <= '0;
         wdata_q <= '0;
         for (int r = 0; r < ROWS; r++)
            act_q[r] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         acc_q   <= acc_d;
         err_q   <= err_d;
         wr_en_q <= wr_en_d;
         row_q   <= row_d;
         wdata_q <= wdata_d;
         if (act_we) act_q[cnt_q] <= bus.cmd_data;
      end
   end

   dcim_byte_ser u_ser (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (ser_load),
      .data_i  (acc_d),
      .ready_i (bus.res_ready),
      .valid_o (bus.res_valid),
      .data_o  (bus.res_data),
      .done_o  (ser_done)
   );

endmodule

// File: tb/tb_dcim_seq_ctrl.sv
// Directed bench for dcim_seq_ctrl with a behavioural 8-row array model.
// Honours DCIM_SIGNED_ACT_EN for the expected all-ones result.
module tb_dcim_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        busy;
   logic        err;
   logic        arr_wr_en;
   logic [2:0]  arr_row;
   logic [7:0]  arr_wdata;
   logic [7:0]  arr_act;
   logic [10:0] arr_psum;

   logic [7:0]  w  [8];
   logic [7:0]  av [8];
   logic [7:0]  wv [8];

   int errs   = 0;
   int checks = 0;

   dcim_if bus ();

   dcim_seq_ctrl #(.ROWS(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .busy      (busy),
      .err       (err),
      .arr_wr_en (arr_wr_en),
      .arr_row   (arr_row),
      .arr_wdata (arr_wdata),
      .arr_act   (arr_act),
      .arr_psum  (arr_psum)
   );

   always #5 clk = ~clk;

   initial for (int r = 0; r < 8; r++) w[r] = 8'h00;

   always @(posedge clk)
      if (arr_wr_en) w[arr_row] <= arr_wdata;

   always_comb begin
      arr_psum = '0;
      for (int r = 0; r < 8; r++)
         if (arr_act[r]) arr_psum = arr_psum + 11'(w[r]);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = b;
      step();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
         errs++;
         $display("FAIL reset_ctrl: rdy=%b busy=%b err=%b want 1 0 0",
                  bus.cmd_ready, busy, err);
      end
      checks++;
      if (bus.res_valid !== 1'b0 || bus.res_data !== 8'h00) begin
         errs++;
         $display("FAIL reset_res: valid=%b data=%h want 0 00",
                  bus.res_valid, bus.res_data);
      end
      checks++;
      if (arr_wr_en !== 1'b0 || arr_row !== 3'd0 ||
          arr_wdata !== 8'h00 || arr_act !== 8'h00) begin
         errs++;
         $display("FAIL reset_arr: we=%b row=%0d wd=%h act=%h want all 0",
                  arr_wr_en, arr_row, arr_wdata, arr_act);
      end
   endtask

   task automatic test_load_w();
      send(8'h01);
      checks++;
      if (busy !== 1'b1 || arr_wr_en !== 1'b0) begin
         errs++;
         $display("FAIL loadw_enter: busy=%b we=%b want 1 0", busy, arr_wr_en);
      end
      bus.cmd_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bus.cmd_data = wv[k];
         step();
         checks++;
         if (arr_wr_en !== 1'b1 || arr_row !== 3'(k) || arr_wdata !== wv[k]) begin
            errs++;
            $display("FAIL loadw_pulse%0d: we=%b row=%0d wd=%h want 1 %0d %h",
                     k, arr_wr_en, arr_row, arr_wdata, k, wv[k]);
         end
      end
      bus.cmd_valid = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errs++;
         $display("FAIL loadw_idle: busy=%b want 0", busy);
      end
      step();
      checks++;
      if (arr_wr_en !== 1'b0) begin
         errs++;
         $display("FAIL loadw_strobe_end: we=%b want 0", arr_wr_en);
      end
   endtask

   task automatic test_run(input bit with_op, input logic [23:0] exp,
                           input int bp, input string nm);
      logic [7:0] ea;
      int         n;
      if (with_op) send(8'h02);
      bus.cmd_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bus.cmd_data = av[k];
         step();
      end
      bus.cmd_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         for (int r = 0; r < 8; r++) ea[r] = av[r][8 - c];
         checks++;
         if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b0 || arr_act !== ea) begin
            errs++;
            $display("FAIL %s_compute%0d: valid=%b rdy=%b act=%h want 0 0 %h",
                     nm, c, bus.res_valid, bus.cmd_ready, arr_act, ea);
         end
         step();
      end
      checks++;
      if (bus.res_valid !== 1'b1) begin
         errs++;
         $display("FAIL %s_latency: res_valid=%b want 1 at T+9", nm, bus.res_valid);
      end
      for (int i = 0; i < 3; i++) begin
         n = 0;
         while (bus.res_valid !== 1'b1 && n < 20) begin
            step();
            n++;
         end
         checks++;
         if (bus.res_valid !== 1'b1) begin
            errs++;
            $display("FAIL %s_timeout%0d: res_valid never rose", nm, i);
         end
         if (i == 0 && bp > 0) begin
            bus.res_ready = 1'b0;
            for (int c = 0; c < bp; c++) begin
               step();
               checks++;
               if (bus.res_valid !== 1'b1 || bus.res_data !== exp[7:0] ||
                   bus.cmd_ready !== 1'b0) begin
                  errs++;
                  $display("FAIL %s_hold%0d: valid=%b data=%h rdy=%b want 1 %h 0",
                           nm, c, bus.res_valid, bus.res_data, bus.cmd_ready,
                           exp[7:0]);
               end
            end
         end
         checks++;
         if (bus.res_data !== exp[8*i +: 8]) begin
            errs++;
            $display("FAIL %s_byte%0d: got %h want %h",
                     nm, i, bus.res_data, exp[8*i +: 8]);
         end
         bus.res_ready = 1'b1;
         step();
      end
      bus.res_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         errs++;
         $display("FAIL %s_done: busy=%b valid=%b rdy=%b want 0 0 1",
                  nm, busy, bus.res_valid, bus.cmd_ready);
      end
   endtask

   task automatic test_err();
      send(8'h7E);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         errs++;
         $display("FAIL err_set: err=%b busy=%b want 1 0", err, busy);
      end
      send(8'h02);
      checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         errs++;
         $display("FAIL err_clear: err=%b busy=%b want 0 1", err, busy);
      end
      for (int k = 0; k < 8; k++) av[k] = 8'h01;
      test_run(1'b0, 24'h000024, 0, "err_run");
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      send(8'h02);
      bus.cmd_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bus.cmd_data = 8'hFF;
         step();
      end
      bus.cmd_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++;
      if (busy !== 1'b0 || bus.cmd_ready !== 1'b1 || arr_act !== 8'h00) begin
         errs++;
         $display("FAIL rstmid_idle: busy=%b rdy=%b act=%h want 0 1 00",
                  busy, bus.cmd_ready, arr_act);
      end
      bus.res_ready = 1'b1;
      for (int c = 0; c < 15; c++) begin
         if (bus.res_valid !== 1'b0) seen++;
         step();
      end
      bus.res_ready = 1'b0;
      checks++;
      if (seen != 0) begin
         errs++;
         $display("FAIL rstmid_novalid: res_valid seen %0d cycles want 0", seen);
      end
      for (int k = 0; k < 8; k++) av[k] = 8'h01;
      test_run(1'b1, 24'h0007F8, 0, "rstmid_run");
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = 8'h00;
      bus.res_ready = 1'b0;

      test_reset();

      for (int k = 0; k < 8; k++) wv[k] = 8'(k + 1);
      test_load_w();

      for (int k = 0; k < 8; k++) av[k] = 8'h01;
      test_run(1'b1, 24'h000024, 0, "run_ones");

      for (int k = 0; k < 8; k++) av[k] = 8'(16 * k + k + 1);
      test_run(1'b1, 24'h000B4C, 5, "backpressure");

      test_err();

      for (int k = 0; k < 8; k++) wv[k] = 8'hFF;
      test_load_w();
      for (int k = 0; k < 8; k++) av[k] = 8'hFF;
`ifdef DCIM_SIGNED_ACT_EN
      test_run(1'b1, 24'hFFF808, 0, "all_ff");
`else
      test_run(1'b1, 24'h07F008, 0, "all_ff");
`endif

      test_reset_mid();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/dcim_seq_ctrl.md
# dcim_seq_ctrl

Sequencer for the TinyDCIM bit-serial compute-in-memory array; it sits between the pin-level byte interface and the array macro. It decodes a host byte stream into weight writes and activation loads. It then drives the array through one bit-plane per cycle, shift-accumulates the array's partial sums, and streams the accumulated result back as bytes.

## Interface
- `ROWS`, 8: number of array rows (weights/activations per dot product), power of two, 2..16
- `clk` in 1: clock
- `rst_n` in 1: reset, synchronous, active-low
- `cmd_valid` in 1: host byte valid
- `cmd_ready` out 1: controller accepts byte; transfer when both high
- `cmd_data` in 8: opcode or payload byte
- `res_valid` out 1: result byte valid
- `res_ready` in 1: host accepts result byte
- `res_data` out 8: result byte, LSB-first
- `busy` out 1: state ≠ IDLE
- `err` out 1: sticky unknown-opcode flag
- `arr_wr_en` out 1: one-cycle weight write strobe
- `arr_row` out $clog2(ROWS): weight write row
- `arr_wdata` out 8: weight write data
- `arr_act` out ROWS: current activation bit-plane, bit r = row r
- `arr_psum` in 8+$clog2(ROWS): array combinational sum of weights whose `arr_act` bit is 1

## Operation
- States: IDLE, LOAD_W, LOAD_A, COMPUTE, DRAIN.
- IDLE: `cmd_ready`=1. Opcode 0x01 → LOAD_W. Opcode 0x02 → LOAD_A. Any other opcode → `err`=1, stay IDLE. A valid opcode clears `err`.
- LOAD_W: `cmd_ready`=1. Byte k (0..ROWS-1) is accepted at cycle t. At t+1: `arr_wr_en`=1, `arr_row`=k, `arr_wdata`=byte. After byte ROWS-1 → IDLE.
- LOAD_A: `cmd_ready`=1. Byte k is stored in internal `act[k]`. After byte ROWS-1 → COMPUTE, and `acc` is cleared.
- COMPUTE: `cmd_ready`=0. Runs 8 cycles with bit index b = 7 down to 0. `arr_act[r]` = `act[r][b]`. Each cycle: `acc <= (acc<<1) + zext(arr_psum)`. After b=0 → DRAIN.
- DRAIN: `cmd_ready`=0. Emits 3 bytes of the 24-bit `acc`, LSB first. `res_data` and `res_valid` are held stable until `res_ready`. After byte 2 handshakes → IDLE.
- Arithmetic: `acc` is 24 bits, modulo 2^24. No overflow is possible for ROWS≤16.
- `arr_act`=0 outside COMPUTE. `arr_wr_en`=0 outside the cycle after a LOAD_W accept.

## Timing
- Reset (`rst_n` low at a clock edge): state=IDLE, counters=0, `acc`=0, `act`=0, `err`=0.
- Outputs from the next cycle after reset: `cmd_ready`=1, `busy`=0, `res_valid`=0, `res_data`=0, `arr_wr_en`=0, `arr_row`=0, `arr_wdata`=0, `arr_act`=0.
- Reset mid-operation aborts immediately. No partial result is emitted. Array weights are untouched.
- Last activation accepted at cycle T: COMPUTE runs T+1..T+8, first `res_valid` at T+9.
- Minimum RUN transaction: 1+ROWS+8+3 cycles. The earliest next opcode is accepted the cycle after the last result handshake.
- `cmd_valid` during COMPUTE/DRAIN is ignored, not dropped; the host holds the byte.
- `cmd_ready` is a function of state only. There is no combinational path from `cmd_valid` or `res_ready` to any ready/valid output.

## Configuration
- `DCIM_SIGNED_ACT_EN` defined: activations are two's complement. At b=7: `acc <= (acc<<1) - zext(arr_psum)`. Result is 24-bit two's complement.
- Undefined: all planes add, and the result is unsigned.

## Structure
- Package `dcim_pkg` holds:
  - state enum
  - opcode constants `OP_LOAD_W`=0x01, `OP_RUN`=0x02
  - `ACC_W`=24, `RES_BYTES`=3, `ACT_BITS`=8
- One sub-module, `dcim_byte_ser`: a 24-bit load, 8-bit valid/ready LSB-first serializer used by DRAIN.

## Test plan
Bench array model: `arr_psum` = Σ w[r]·`arr_act[r]`, ROWS=8.
- LOAD_W: 0x01, then 0x01..0x08 → 8 `arr_wr_en` pulses, rows 0..7, data 1..8. Then `busy`=0.
- RUN with weights 1..8: 0x02, then eight 0x01 → result bytes 0x24, 0x00, 0x00; `res_valid` 9 cycles after the last activation.
- Weights all 0xFF, RUN with activations all 0xFF:
  - unsigned build → 0x08, 0xF0, 0x07
  - `DCIM_SIGNED_ACT_EN` build → 0x08, 0xF8, 0xFF
- Backpressure: `res_ready` low 5 cycles in DRAIN → `res_valid`/`res_data` stable, `cmd_ready`=0, no byte lost.
- Opcode 0x7E → `err`=1, state IDLE. A following 0x02 clears `err` and enters LOAD_A.
- `rst_n` low at COMPUTE cycle 3 → IDLE next cycle, `res_valid` never asserts. A subsequent full RUN gives the correct result.
